mm_arb: RTL and testbench
=========================

MM_ARB -- requirements
Module: mm_arb

Interface
REQ-001 Parameter: TIMEOUT, 64, cycles allowed in a wait state before abort (used only when MM_ARB_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 c0_a / c1_a  input  32  requester line address; bits [31:5] are used, [4:0] are ignored.
REQ-005 c0_read / c1_read  input  1  read request; held high until the matching cN_ready pulse.
REQ-006 c0_write / c1_write  input  1  write (evict) request; held high until the matching cN_ready pulse.
REQ-007 c0_wd / c1_wd  input  256  write line data; stable while the request is held.
REQ-008 c0_rd / c1_rd  output  256  returned read line.
REQ-009 c0_rd_valid / c1_rd_valid  output  1  one-cycle pulse marking cN_rd valid.
REQ-010 c0_ready / c1_ready  output  1  one-cycle pulse: request accepted.
REQ-011 mm_a  output  27  line address to main memory.
REQ-012 mm_read / mm_write  output  1  one-cycle command pulses to main memory.
REQ-013 mm_wd  output  256  write line to main memory.
REQ-014 mm_rd  input  256  read line from main memory.
REQ-015 mm_valid  input  1  mm_rd valid.
REQ-016 mm_ready  input  1  main memory can accept a command.
REQ-017 timeout_err  output  1  one-cycle pulse on transaction abort.

Function
REQ-018 The arbiter SHALL use three states: IDLE, RD_WAIT, WR_WAIT.
REQ-019 In IDLE with mm_ready=1 and at least one request pending, it SHALL grant exactly one requester at that edge.
REQ-020 With both requesters pending, it SHALL grant the one not granted last (round-robin); a single pending requester SHALL always win.
REQ-021 The grant SHALL register mm_a=cN_a[31:5] and mm_wd=cN_wd, and SHALL pulse mm_read or mm_write and cN_ready in the following cycle, so accept latency is 1 cycle.
REQ-022 If a requester drives read and write together, read SHALL win; the write SHALL stay pending and be arbitrated again later.
REQ-023 After a read grant the state SHALL be RD_WAIT; on the edge where mm_valid=1 the block SHALL register mm_rd into the granted cN_rd, pulse cN_rd_valid in the next cycle, and return to IDLE.
REQ-024 After a write grant the state SHALL be WR_WAIT; it SHALL stay for at least one cycle, then return to IDLE on the first edge with mm_ready=1.
REQ-025 A new grant SHALL NOT be issued outside IDLE; the earliest next grant is the edge after returning to IDLE.
REQ-026 The non-granted requester's rd_valid and ready SHALL stay 0 throughout.
REQ-027 The block SHALL ignore mm_valid while in IDLE or WR_WAIT.
REQ-028 cN_rd SHALL hold its last value until the next read return for that requester.

Reset
REQ-029 Asserting reset (low) SHALL asynchronously force: state=IDLE, round-robin pointer favouring c0, all pulse outputs=0, mm_a=0, mm_wd=0, c0_rd=c1_rd=0, watchdog counter=0.
REQ-030 Reset mid-transaction SHALL abandon the transaction with no rd_valid pulse; a later stray mm_valid SHALL be ignored.
REQ-031 The block SHALL leave reset synchronously, on the first posedge clk after reset rises.

Configuration
REQ-032 Macro MM_ARB_TIMEOUT_EN: when defined, a counter SHALL run in RD_WAIT and WR_WAIT, clearing on entry to either state.
REQ-033 When the counter reaches TIMEOUT, the block SHALL return to IDLE, pulse timeout_err for one cycle, and assert no rd_valid.
REQ-034 When MM_ARB_TIMEOUT_EN is undefined, there SHALL be no counter, timeout_err SHALL be tied 0, and wait states SHALL wait indefinitely.

Verification
REQ-035 Single read: c0_read with a=0x0000_1240 -> c0_ready 1 cycle later, mm_a=0x92, one mm_read pulse; with a 4-cycle memory latency, c0_rd_valid follows 1 cycle after mm_valid and c0_rd equals mm_rd.
REQ-036 Contention: c0_read and c1_read both asserted from IDLE after reset -> c0 granted first, c1 granted after c0_rd_valid, then c0 again if it re-requests.
REQ-037 Write then read: c1_write with wd=256'hA5..A5 -> one mm_write pulse with mm_wd matching; c1_read is not granted until mm_ready returns high after at least 1 cycle.
REQ-038 Read+write from the same requester -> read serviced first, write granted after return to IDLE.
REQ-039 Reset pulled low 2 cycles after a read grant -> no c0_rd_valid, all outputs 0; a late mm_valid produces no response.
REQ-040 MM_ARB_TIMEOUT_EN defined, TIMEOUT=8, mm_valid never asserted -> timeout_err pulses 8 cycles after entering RD_WAIT, state returns to IDLE, no rd_valid.

Source files
------------

// File: rtl/mm_arb.sv
// mm_arb: two-requester round-robin arbiter in front of a line-based main memory.
// Build option: define MM_ARB_TIMEOUT_EN to add a watchdog that aborts a wait
// state after TIMEOUT cycles and pulses timeout_err.
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | nothing outstanding; may grant one requester
// RD_WAIT | read command issued, waiting for mm_valid
// WR_WAIT | write command issued, waiting for mm_ready

module mm_arb #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  c0_a,
    input  logic         c0_read,
    input  logic         c0_write,
    input  logic [255:0] c0_wd,
    output logic [255:0] c0_rd,
    output logic         c0_rd_valid,
    output logic         c0_ready,
    input  logic [31:0]  c1_a,
    input  logic         c1_read,
    input  logic         c1_write,
    input  logic [255:0] c1_wd,
    output logic [255:0] c1_rd,
    output logic         c1_rd_valid,
    output logic         c1_ready,
    output logic [26:0]  mm_a,
    output logic         mm_read,
    output logic         mm_write,
    output logic [255:0] mm_wd,
    input  logic [255:0] mm_rd,
    input  logic         mm_valid,
    input  logic         mm_ready,
    output logic         timeout_err
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t state, state_nxt;
    logic   rr_c1;       // 1: c1 wins the next tie
    logic   gnt_id;      // owner of the outstanding transaction
    logic   grant, gnt_sel, gnt_rd, rd_done, tmo_abort, tmo_hit;
    logic   c0_pend, c1_pend;
    logic   unused_addr_bits;

    assign c0_pend = c0_read | c0_write;
    assign c1_pend = c1_read | c1_write;

    // Line offset bits are don't-care on the request side.
    assign unused_addr_bits = ^{c0_a[4:0], c1_a[4:0]};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and grant decision; read beats write within one requester.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        gnt_sel   = 1'b0;
        gnt_rd    = 1'b0;
        rd_done   = 1'b0;
        tmo_abort = 1'b0;
        case (state)
            IDLE: begin
                if (mm_ready && (c0_pend || c1_pend)) begin
                    grant     = 1'b1;
                    gnt_sel   = (c0_pend && c1_pend) ? rr_c1 : c1_pend;
                    gnt_rd    = gnt_sel ? c1_read : c0_read;
                    state_nxt = gnt_rd ? RD_WAIT : WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (mm_valid) begin
                    rd_done   = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    tmo_abort = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR_WAIT: begin
                if (mm_ready) begin
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    tmo_abort = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command/data registers, one-cycle pulses and read-return capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mm_a        <= '0;
            mm_wd       <= '0;
            mm_read     <= 1'b0;
            mm_write    <= 1'b0;
            c0_ready    <= 1'b0;
            c1_ready    <= 1'b0;
            c0_rd_valid <= 1'b0;
            c1_rd_valid <= 1'b0;
            c0_rd       <= '0;
            c1_rd       <= '0;
            rr_c1       <= 1'b0;
            gnt_id      <= 1'b0;
        end else begin
            mm_read     <= 1'b0;
            mm_write    <= 1'b0;
            c0_ready    <= 1'b0;
            c1_ready    <= 1'b0;
            c0_rd_valid <= 1'b0;
            c1_rd_valid <= 1'b0;
            if (grant) begin
                mm_a     <= gnt_sel ? c1_a[31:5] : c0_a[31:5];
                mm_wd    <= gnt_sel ? c1_wd : c0_wd;
                mm_read  <= gnt_rd;
                mm_write <= ~gnt_rd;
                c0_ready <= ~gnt_sel;
                c1_ready <= gnt_sel;
                gnt_id   <= gnt_sel;
                rr_c1    <= ~gnt_sel;
            end
            if (rd_done) begin
                if (gnt_id) begin
                    c1_rd       <= mm_rd;
                    c1_rd_valid <= 1'b1;
                end else begin
                    c0_rd       <= mm_rd;
                    c0_rd_valid <= 1'b1;
                end
            end
        end
    end

`ifdef MM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] wd_cnt;

    // Reaching zero while still waiting means TIMEOUT cycles have elapsed.
    assign tmo_hit = (state != IDLE) && (wd_cnt == '0);

    // Watchdog down-counter, reloaded on every grant; abort pulse register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_abort;
            if (grant)
                wd_cnt <= CNT_W'(TIMEOUT - 1);
            else if ((state != IDLE) && (wd_cnt != '0))
                wd_cnt <= wd_cnt - 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_cfg  = ^{tmo_abort, (TIMEOUT != 0)};
`endif

endmodule

// File: tb/tb_mm_arb.sv
// Bench for mm_arb: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter.
module tb_mm_arb;

`ifdef MM_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 64;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         c_read [2];
    logic         c_write[2];
    logic [31:0]  c_a    [2];
    logic [255:0] c_wd   [2];
    logic [255:0] c0_rd, c1_rd, mm_wd, mm_rd;
    logic         c0_rd_valid, c1_rd_valid, c0_ready, c1_ready;
    logic [26:0]  mm_a;
    logic         mm_read, mm_write, mm_valid, mm_ready, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus / memory responder controls
    bit           rand_en = 0, dir_ready = 1, mem_noresp = 0, mem_pend = 0;
    int           mem_cnt = 0, mem_lat = 3, drv_k;
    logic [255:0] last_rd = '0;
    logic [255:0] a5_line = {32{8'hA5}};
    int           glog[$];

    // transaction-level model
    bit           busy = 0, busy_read = 0;
    int           owner = 0, last_owner = 1, age = 0, m_w;
    bit           m_pend[2];
    logic         e_ready[2], e_rdv[2];
    logic [255:0] e_rd[2];
    logic [26:0]  e_mm_a = '0;
    logic [255:0] e_mm_wd = '0;
    logic         e_mm_read = 0, e_mm_write = 0, e_tmo = 0;

    mm_arb #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .c0_a(c_a[0]), .c0_read(c_read[0]), .c0_write(c_write[0]), .c0_wd(c_wd[0]),
        .c0_rd(c0_rd), .c0_rd_valid(c0_rd_valid), .c0_ready(c0_ready),
        .c1_a(c_a[1]), .c1_read(c_read[1]), .c1_write(c_write[1]), .c1_wd(c_wd[1]),
        .c1_rd(c1_rd), .c1_rd_valid(c1_rd_valid), .c1_ready(c1_ready),
        .mm_a(mm_a), .mm_read(mm_read), .mm_write(mm_write), .mm_wd(mm_wd),
        .mm_rd(mm_rd), .mm_valid(mm_valid), .mm_ready(mm_ready),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic sig_of(input int w);
        case (w)
            0: return c0_ready;
            1: return c1_ready;
            2: return c0_rd_valid;
            3: return c1_rd_valid;
            default: return timeout_err;
        endcase
    endfunction

    task automatic wait_for(input int w, input int budget, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (sig_of(w)) return;
            if (cyc >= budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL wait_%0d: event not seen within %0d cycles", w, budget);
                return;
            end
        end
    endtask

    task automatic wait_log(input int n, input int budget);
        int c = 0;
        while (glog.size() < n) begin
            @(negedge clk);
            c++;
            if (c > budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL wait_log: %0d grants seen, %0d required", glog.size(), n);
                return;
            end
        end
    endtask

    // Model: at most one transaction in flight; round-robin on ties, read before write.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy = 0; busy_read = 0; last_owner = 1; age = 0; owner = 0;
            for (int i = 0; i < 2; i++) begin
                e_ready[i] = 0; e_rdv[i] = 0; e_rd[i] = '0;
            end
            e_mm_a = '0; e_mm_wd = '0; e_mm_read = 0; e_mm_write = 0; e_tmo = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                e_ready[i] = 0; e_rdv[i] = 0;
                m_pend[i]  = c_read[i] | c_write[i];
            end
            e_mm_read = 0; e_mm_write = 0; e_tmo = 0;
            if (!busy) begin
                if (mm_ready && (m_pend[0] || m_pend[1])) begin
                    if (m_pend[0] && m_pend[1]) m_w = 1 - last_owner;
                    else                        m_w = m_pend[1] ? 1 : 0;
                    last_owner = m_w; owner = m_w; busy = 1; age = 0;
                    busy_read  = c_read[m_w];
                    e_mm_a     = c_a[m_w][31:5];
                    e_mm_wd    = c_wd[m_w];
                    e_mm_read  = c_read[m_w];
                    e_mm_write = !c_read[m_w];
                    e_ready[m_w] = 1;
                end
            end else if (busy_read ? mm_valid : mm_ready) begin
                busy = 0;
                if (busy_read) begin
                    e_rd[owner]  = mm_rd;
                    e_rdv[owner] = 1;
                end
            end else begin
`ifdef MM_ARB_TIMEOUT_EN
                age++;
                if (age >= TB_TIMEOUT) begin
                    busy  = 0;
                    e_tmo = 1;
                end
`endif
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("c0_ready", c0_ready, e_ready[0]);
        chk("c1_ready", c1_ready, e_ready[1]);
        chk("c0_rd_valid", c0_rd_valid, e_rdv[0]);
        chk("c1_rd_valid", c1_rd_valid, e_rdv[1]);
        chk("c0_rd", c0_rd, e_rd[0]);
        chk("c1_rd", c1_rd, e_rd[1]);
        chk("mm_a", mm_a, e_mm_a);
        chk("mm_wd", mm_wd, e_mm_wd);
        chk("mm_read", mm_read, e_mm_read);
        chk("mm_write", mm_write, e_mm_write);
        chk("timeout_err", timeout_err, e_tmo);
    end

    // Grant log: 2*id + is_read.
    always @(negedge clk) begin
        if (c0_ready) glog.push_back(mm_read ? 1 : 0);
        if (c1_ready) glog.push_back(mm_read ? 3 : 2);
    end

    // Requesters drop on ready; random traffic; main-memory responder.
    always @(posedge clk) begin
        #1;
        if (c0_ready) begin if (c_read[0]) c_read[0] = 0; else c_write[0] = 0; end
        if (c1_ready) begin if (c_read[1]) c_read[1] = 0; else c_write[1] = 0; end
        if (rand_en) begin
            for (int n = 0; n < 2; n++) begin
                if (!c_read[n] && !c_write[n] && $urandom_range(0, 2) == 0) begin
                    drv_k      = $urandom_range(0, 3);
                    c_read[n]  = (drv_k != 2);
                    c_write[n] = (drv_k >= 2);
                    c_a[n]     = $urandom;
                    c_wd[n]    = {$urandom, $urandom, $urandom, $urandom,
                                  $urandom, $urandom, $urandom, $urandom};
                end
            end
        end
        if (mm_read) begin
            mem_pend = 1;
            mem_cnt  = rand_en ? $urandom_range(0, 4) : mem_lat;
        end
        mm_valid = 0;
        if (mem_pend) begin
            if (!mem_noresp) begin
                if (mem_cnt == 0) begin
                    mm_valid = 1;
                    mm_rd    = {$urandom, $urandom, $urandom, $urandom,
                                $urandom, $urandom, $urandom, $urandom};
                    last_rd  = mm_rd;
                    mem_pend = 0;
                end else begin
                    mem_cnt--;
                end
            end
        end else if (rand_en && $urandom_range(0, 7) == 0) begin
            mm_valid = 1;
            mm_rd    = {8{$urandom}};
        end
        mm_ready = rand_en ? ($urandom_range(0, 3) != 0) : dir_ready;
    end

    initial begin
        int cyc, cnt;
        for (int i = 0; i < 2; i++) begin
            c_read[i] = 0; c_write[i] = 0; c_a[i] = '0; c_wd[i] = '0;
        end
        mm_valid = 0; mm_rd = '0; mm_ready = 1;
        repeat (2) @(posedge clk);
        #3 reset = 1;
        @(negedge clk);
        chk("rst_mm_a", mm_a, 0);
        chk("rst_c0_rd", c0_rd, 0);

        // contention from reset: c0, then c1, then c0 again
        glog.delete();
        c_a[0] = 32'h0000_0100; c_a[1] = 32'h0000_0200;
        c_read[0] = 1; c_read[1] = 1;
        wait_log(2, 60);
        c_read[0] = 1;
        wait_log(3, 60);
        chk("ct_first", glog[0], 1);
        chk("ct_second", glog[1], 3);
        chk("ct_third", glog[2], 1);
        repeat (15) @(negedge clk);

        // single read, address 0x1240 -> line 0x92
        mem_lat = 3;
        c_a[0] = 32'h0000_1240; c_read[0] = 1;
        wait_for(0, 20, cyc);
        chk("sr_accept_lat", cyc, 1);
        chk("sr_mm_a", mm_a, 27'h92);
        chk("sr_model_mm_a", e_mm_a, 27'h92);
        chk("sr_mm_read", mm_read, 1);
        wait_for(2, 40, cyc);
        chk("sr_rdv_lat", cyc, 4);
        chk("sr_c0_rd", c0_rd, last_rd);
        repeat (5) @(negedge clk);

        // write then read from c1, memory busy after the write
        c_a[1] = 32'h0000_0400; c_wd[1] = a5_line; c_write[1] = 1; dir_ready = 0;
        wait_for(1, 20, cyc);
        chk("wr_mm_write", mm_write, 1);
        chk("wr_mm_wd", mm_wd, a5_line);
        chk("wr_mm_a", mm_a, 27'h20);
        c_read[1] = 1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (c1_ready) cnt++;
        end
        chk("wr_hold_off", cnt, 0);
        dir_ready = 1;
        wait_for(1, 20, cyc);
        chk("wr_then_rd_lat", cyc, 3);
        chk("wr_then_rd", mm_read, 1);
        wait_for(3, 40, cyc);
        repeat (5) @(negedge clk);

        // read+write from the same requester: read first
        glog.delete();
        c_a[0] = 32'h0000_0300; c_wd[0] = {8{32'h1234_5678}};
        c_read[0] = 1; c_write[0] = 1;
        wait_log(2, 60);
        chk("rw_first_read", glog[0], 1);
        chk("rw_then_write", glog[1], 0);
        repeat (10) @(negedge clk);

        // randomized traffic
        rand_en = 1;
        repeat (3000) @(negedge clk);
        rand_en = 0;
        repeat (60) @(negedge clk);

        // reset two cycles after a read grant
        mem_lat = 12;
        c_a[0] = 32'h0000_0800; c_read[0] = 1;
        wait_for(0, 20, cyc);
        repeat (2) @(posedge clk);
        #3 reset = 0;
        #1;
        chk("mid_rst_c0_rdv", c0_rd_valid, 0);
        chk("mid_rst_mm_a", mm_a, 0);
        chk("mid_rst_c0_rd", c0_rd, 0);
        chk("mid_rst_mm_wd", mm_wd, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (c0_rd_valid || c1_rd_valid) cnt++;
        end
        chk("late_valid_ignored", cnt, 0);

`ifdef MM_ARB_TIMEOUT_EN
        // memory never answers: abort after TB_TIMEOUT cycles
        mem_noresp = 1;
        c_a[1] = 32'h0000_0900; c_read[1] = 1;
        wait_for(1, 20, cyc);
        wait_for(4, 40, cyc);
        chk("tmo_cycles", cyc, 8);
        chk("tmo_no_rdv", c1_rd_valid, 0);
        mem_noresp = 0;
        mem_pend   = 0;
        repeat (5) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
